vce_cram_loader: RTL and testbench
==================================

# vce_cram_loader

Bus-master engine that drives the HuC6260 VCE's CPU-side MMIO port (A, D, RD_n, WR_n, CS_n) to bulk-load or bulk-dump color RAM. It optionally writes the control register, then the color table address, then streams 9-bit colors in (load) or out (dump). Its bus timing satisfies the VCE's clk7-rate strobe edge detection. It sits beside the CPU as an alternate master for boot-time palette init and for palette readback in verification.

## Interface
- LOW_CYC, 3: clocks each strobe is held low per access (≥3 so that a divide-by-3 MMIO tick always lands inside it).
- HIGH_CYC, 3: clocks each strobe is held high after each access (≥3 so that the VCE re-arms its edge detector).
- clock  in  1  system clock.
- reset_N  in  1  asynchronous, active-low reset.
- start  in  1  command request; sampled only in IDLE.
- op  in  1  0 = load (write CRAM), 1 = dump (read CRAM).
- set_cr  in  1  write cr_val to register 0 before addressing.
- cr_val  in  8  control register value.
- base  in  9  first color index.
- count  in  9  number of entries minus 1 (0 → 1 entry, 511 → 512 entries).
- in_data  in  9  load color {G[2:0],R[2:0],B[2:0]}.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts in_data.
- out_data  out  9  dumped color.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- A  out  3  VCE register address.
- D_out  out  8  write data.
- D_oe  out  1  drive D_out onto the D bus.
- D_in  in  8  read data from the D bus.
- RD_n, WR_n, CS_n  out  1 each  active-low bus strobes.

## Operation
- States: IDLE, CR_WR, CTA_LO, CTA_HI, FETCH, WR_LO, WR_HI, RD_LO, RD_HI, PUSH, DONE.
- IDLE + start: latch op, set_cr, cr_val, base, count into internal registers; remaining counter = count.
  - Next state is CR_WR if set_cr = 1, otherwise CTA_LO.
  - start is ignored while busy.
- Fixed write sequence:
  - CR_WR: A=0, D=cr_val.
  - CTA_LO: A=2, D=base[7:0].
  - CTA_HI: A=3, D={7'b0, base[8]}.
  - After CTA_HI, go to FETCH (op = 0) or RD_LO (op = 1).
- Load path:
  - FETCH: in_ready = 1; on in_valid & in_ready, capture in_data and go to WR_LO.
  - WR_LO: A=4, D=data[7:0].
  - WR_HI: A=5, D={7'b0, data[8]}. The VCE auto-increments CTA here.
- Dump path:
  - RD_LO: A=4 read; capture D_in into data[7:0].
  - RD_HI: A=5 read; capture D_in[0] into data[8]. The VCE auto-increments CTA here.
  - PUSH: out_valid = 1 with out_data = data; leave on out_ready.
- After WR_HI or PUSH: if remaining = 0 go to DONE, otherwise decrement remaining and go to FETCH or RD_LO.
- DONE: pulse done for one cycle, return to IDLE.
- Index wraps 511 → 0 in the VCE's 9-bit CTA; the loader does nothing special at the wrap.

## Timing
- Every bus state lasts LOW_CYC+HIGH_CYC clocks, tracked by phase counter p = 0..5.
  - A, D_out, D_oe are stable for all phases.
  - CS_n and the active strobe (WR_n or RD_n) are low for p < LOW_CYC and high otherwise.
  - The inactive strobe stays high.
- D_oe = 1 during write-bus states, 0 otherwise.
- Reads capture D_in on the clock edge that ends phase LOW_CYC-1, while the strobe is still low.
- FETCH and PUSH take at least 1 clock each; they add cycles only while in_valid or out_ready is low.
- start accepted at edge k:
  - busy = 1 from cycle k+1; first bus phase 0 is in cycle k+1.
  - done = 1 and busy = 0 in the cycle after the final phase 5.
  - busy returns to 1 only on the next accepted start.
- Reset values:
  - A = 0, D_out = 0, D_oe = 0.
  - RD_n = WR_n = CS_n = 1.
  - in_ready = out_valid = busy = done = 0; out_data = 0; state IDLE.
- Reset asserted mid-access: strobes go high asynchronously and the partial access is abandoned. CRAM contents at that point are undefined.

## Test plan
- Reset: hold reset_N = 0 with random inputs → all strobes 1, busy/done/D_oe 0. Release → IDLE, no bus activity.
- Single load: set_cr = 1, cr_val = 8'h02, base = 9'h010, count = 0, in_data = 9'h1A5, in_valid held → bus writes A0=02, A2=10, A3=00, A4=A5, A5=01. Each WR_n low exactly 3 clocks. done at k+32. VCE CRAM[0x010] = 1A5.
- Wrapped load: base = 9'h1FF, count = 1, data 9'h001 then 9'h1FE, with in_valid stalled 5 cycles before the second word → CRAM[1FF] = 001, CRAM[000] = 1FE. done delayed by exactly 5 cycles versus the no-stall case.
- Dump: preload CRAM[0x020..0x023] = 000, 0FF, 100, 1FF; set_cr = 0, base = 9'h020, count = 3, op = 1, out_ready = 1 → out_data sequence 000, 0FF, 100, 1FF. First entry: done at k+26.
- Backpressure: during a dump, hold out_ready = 0 for 10 cycles → out_valid and out_data held stable, RD_n stays high, no extra CTA increment, sequence intact.
- Mid-operation reset: assert reset_N during WR_LO phase 1 → WR_n/CS_n rise immediately. A new start after release performs a full clean load.

Source files
------------

// File: rtl/vce_cram_loader.sv
`default_nettype none
// ============================================================================
// Module      : vce_cram_loader
// Description : Alternate bus master for the HuC6260 VCE MMIO port. Optionally
//               writes the control register, sets the color table address,
//               then streams 9-bit colors into (load) or out of (dump) CRAM.
//               Every bus access holds its strobe low LOW_CYC clocks and high
//               HIGH_CYC clocks so the VCE's clk7-rate edge detector sees it.
// Revision    : 1.0 - initial release
// ============================================================================
module vce_cram_loader #(
  parameter int LOW_CYC  = 3,
  parameter int HIGH_CYC = 3
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       start,
  input  logic       op,
  input  logic       set_cr,
  input  logic [7:0] cr_val,
  input  logic [8:0] base,
  input  logic [8:0] count,
  input  logic [8:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [8:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] A,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in,
  output logic       RD_n,
  output logic       WR_n,
  output logic       CS_n
);

  localparam int PERIOD = LOW_CYC + HIGH_CYC;
  localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  // Last phase of a bus state, the phase whose closing edge samples D_in,
  // and the first phase with the strobes released.
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_CAP  = PH_W'(LOW_CYC - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(LOW_CYC);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CR_WR  = 4'd1;
  localparam logic [3:0] S_CTA_LO = 4'd2;
  localparam logic [3:0] S_CTA_HI = 4'd3;
  localparam logic [3:0] S_FETCH  = 4'd4;
  localparam logic [3:0] S_WR_LO  = 4'd5;
  localparam logic [3:0] S_WR_HI  = 4'd6;
  localparam logic [3:0] S_RD_LO  = 4'd7;
  localparam logic [3:0] S_RD_HI  = 4'd8;
  localparam logic [3:0] S_PUSH   = 4'd9;
  localparam logic [3:0] S_DONE   = 4'd10;

  logic [3:0]      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            op_q, op_d;
  logic [7:0]      cr_q, cr_d;
  logic [8:0]      base_q, base_d;
  logic [8:0]      rem_q, rem_d;
  logic [8:0]      data_q, data_d;

  logic            w_bus_end;
  logic            w_is_bus;
  logic            w_wr_act;
  logic            w_rd_act;
  logic            w_strobe_lo;

  // State and datapath registers; reset forces IDLE so strobes rise at once.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      op_q    <= 1'b0;
      cr_q    <= 8'd0;
      base_q  <= 9'd0;
      rem_q   <= 9'd0;
      data_q  <= 9'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      op_q    <= op_d;
      cr_q    <= cr_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  // Next-state, phase counter, command latch and read-data capture.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cr_d      = cr_q;
    base_d    = base_q;
    rem_d     = rem_q;
    data_d    = data_q;
    w_bus_end = (phase_q == PH_LAST);
    w_is_bus  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          cr_d    = cr_val;
          base_d  = base;
          rem_d   = count;
          state_d = set_cr ? S_CR_WR : S_CTA_LO;
        end
      end
      S_CR_WR: begin
        w_is_bus = 1'b1;
        if (w_bus_end) state_d = S_CTA_LO;
      end
      S_CTA_LO: begin
        w_is_bus = 1'b1;
        if (w_bus_end) state_d = S_CTA_HI;
      end
      S_CTA_HI: begin
        w_is_bus = 1'b1;
        if (w_bus_end) state_d = op_q ? S_RD_LO : S_FETCH;
      end
      S_FETCH: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: begin
        w_is_bus = 1'b1;
        if (w_bus_end) state_d = S_WR_HI;
      end
      S_RD_LO: begin
        w_is_bus = 1'b1;
        if (phase_q == PH_CAP) data_d[7:0] = D_in;
        if (w_bus_end) state_d = S_RD_HI;
      end
      S_RD_HI: begin
        w_is_bus = 1'b1;
        if (phase_q == PH_CAP) data_d[8] = D_in[0];
        if (w_bus_end) state_d = S_PUSH;
      end
      S_WR_HI, S_PUSH: begin
        w_is_bus = (state_q == S_WR_HI);
        // Entry finished: the VCE has already advanced CTA on the high access.
        if ((state_q == S_WR_HI) ? w_bus_end : out_ready) begin
          if (rem_q == 9'd0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = rem_q - 9'd1;
            state_d = op_q ? S_RD_LO : S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    phase_d = (w_is_bus && !w_bus_end) ? phase_q + PH_W'(1) : '0;
  end

  // Bus and handshake outputs decoded from the current state and phase.
  always_comb begin
    A           = 3'd0;
    D_out       = 8'd0;
    D_oe        = 1'b0;
    w_wr_act    = 1'b0;
    w_rd_act    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    w_strobe_lo = (phase_q < PH_HIGH);
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_CR_WR:  begin A = 3'd0; D_out = cr_q;                w_wr_act = 1'b1; end
      S_CTA_LO: begin A = 3'd2; D_out = base_q[7:0];         w_wr_act = 1'b1; end
      S_CTA_HI: begin A = 3'd3; D_out = {7'd0, base_q[8]};   w_wr_act = 1'b1; end
      S_FETCH:  in_ready = 1'b1;
      S_WR_LO:  begin A = 3'd4; D_out = data_q[7:0];         w_wr_act = 1'b1; end
      S_WR_HI:  begin A = 3'd5; D_out = {7'd0, data_q[8]};   w_wr_act = 1'b1; end
      S_RD_LO:  begin A = 3'd4; w_rd_act = 1'b1; end
      S_RD_HI:  begin A = 3'd5; w_rd_act = 1'b1; end
      S_PUSH:   out_valid = 1'b1;
      S_DONE:   begin busy = 1'b0; done = 1'b1; end
      default:  busy = 1'b0;
    endcase
    D_oe = w_wr_act;
    CS_n = ~((w_wr_act | w_rd_act) & w_strobe_lo);
    WR_n = ~(w_wr_act & w_strobe_lo);
    RD_n = ~(w_rd_act & w_strobe_lo);
  end

  assign out_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_vce_cram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_vce_cram_loader
// Description : Bench for vce_cram_loader with a behavioural VCE (register
//               file, CTA, CRAM) on the MMIO port, directed command table,
//               hand-written corner sequences and randomized commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vce_cram_loader;

  localparam int LOW_CYC  = 3;
  localparam int HIGH_CYC = 3;

  logic       clock = 1'b0;
  logic       reset_N = 1'b1;
  logic       start = 1'b0, op = 1'b0, set_cr = 1'b0;
  logic [7:0] cr_val = 8'd0;
  logic [8:0] base = 9'd0, count = 9'd0, in_data = 9'd0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_valid, busy, done, D_oe, RD_n, WR_n, CS_n;
  logic [8:0] out_data;
  logic [2:0] A;
  logic [7:0] D_out, D_in;

  int checks = 0;
  int errors = 0;

  vce_cram_loader #(.LOW_CYC(LOW_CYC), .HIGH_CYC(HIGH_CYC)) dut (
    .clock(clock), .reset_N(reset_N), .start(start), .op(op), .set_cr(set_cr),
    .cr_val(cr_val), .base(base), .count(count), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in), .RD_n(RD_n), .WR_n(WR_n),
    .CS_n(CS_n)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural VCE ----------------
  logic [8:0]  cram [512];
  logic [8:0]  exp_cram [512];
  logic [8:0]  cta = 9'd0;
  logic [7:0]  vce_cr = 8'd0;
  logic [7:0]  lo_latch = 8'd0;
  int          lo_cnt = 0;
  int          hi_cnt = HIGH_CYC;
  logic [2:0]  acc_a;
  logic [7:0]  acc_d;
  logic        acc_wr;
  logic [11:0] bus_log [$];

  always_comb begin
    D_in = 8'hEE;
    if (!RD_n) begin
      if (A == 3'd4)      D_in = cram[cta][7:0];
      else if (A == 3'd5) D_in = {7'h6A, cram[cta][8]};
    end
  end

  // One sample per clock: measure strobe widths, commit an access when its
  // strobe rises, abandon it if reset arrives mid-access.
  always @(negedge clock) begin : vce_model
    logic wr, rd;
    wr = !WR_n;
    rd = !RD_n;
    if (!reset_N) begin
      lo_cnt = 0;
      hi_cnt = HIGH_CYC;
    end else if (wr || rd) begin
      chk("cs_with_strobe", CS_n, 1'b0);
      if (lo_cnt == 0) begin
        chk("strobe_high_time", hi_cnt >= HIGH_CYC, 1'b1);
        chk("d_oe_dir", D_oe, wr);
        acc_a  = A;
        acc_d  = D_out;
        acc_wr = wr;
      end else begin
        chk("bus_stable", {acc_a, acc_d, acc_wr}, {A, D_out, wr});
      end
      lo_cnt++;
      hi_cnt = 0;
    end else begin
      if (lo_cnt > 0) begin
        chk("strobe_low_time", lo_cnt, LOW_CYC);
        bus_log.push_back({acc_wr, acc_a, acc_d});
        if (acc_wr) begin
          case (acc_a)
            3'd0: vce_cr = acc_d;
            3'd2: cta[7:0] = acc_d;
            3'd3: cta[8] = acc_d[0];
            3'd4: lo_latch = acc_d;
            3'd5: begin cram[cta] = {acc_d[0], lo_latch}; cta = cta + 9'd1; end
            default: ;
          endcase
        end else if (acc_a == 3'd5) begin
          cta = cta + 9'd1;
        end
      end
      lo_cnt = 0;
      hi_cnt++;
    end
  end

  // ---------------- stimulus / reference ----------------
  logic [8:0] ld_data  [512];
  int         ld_stall [512];
  int         rd_stall [512];

  // Expected done latency: address phase writes, 13 clocks per entry
  // (two 6-clock accesses plus one FETCH/PUSH clock), plus stall clocks.
  function automatic int ref_latency(input logic sc, input int n, input int stalls);
    return 1 + 6 * (2 + int'(sc)) + 13 * n + stalls;
  endfunction

  task automatic clear_stalls();
    for (int i = 0; i < 512; i++) begin
      ld_stall[i] = 0;
      rd_stall[i] = 0;
    end
  endtask

  task automatic run_cmd(input logic op_i, input logic sc_i, input logic [7:0] cr_i,
                         input logic [8:0] base_i, input logic [8:0] cnt_i, input int exp_lat);
    int cyc, wi, ri, st, n, mism;
    logic got_done, busy_bad;
    logic [8:0] held, idx;
    n = int'(cnt_i) + 1;
    bus_log.delete();
    @(negedge clock);
    op = op_i; set_cr = sc_i; cr_val = cr_i; base = base_i; count = cnt_i; start = 1'b1;
    @(negedge clock);
    // Command inputs are latched; scramble them to prove it.
    start = 1'b0; op = 1'($urandom); set_cr = 1'($urandom); cr_val = 8'($urandom);
    base = 9'($urandom); count = 9'($urandom);
    cyc = 1; wi = 0; ri = 0; st = 0; got_done = 1'b0; busy_bad = 1'b0; held = 9'd0;
    chk("busy_after_start", busy, 1'b1);
    while (!got_done && cyc < 20000) begin
      if (in_valid) begin in_valid = 1'b0; wi++; st = 0; end
      if (out_ready) begin out_ready = 1'b0; ri++; st = 0; end
      if (done) begin
        got_done = 1'b1;
        start = 1'b0;
        chk("done_latency", cyc, exp_lat);
        chk("busy_at_done", busy, 1'b0);
      end else begin
        if (!busy) busy_bad = 1'b1;
        start = 1'($urandom);
        if (in_ready && wi < 512) begin
          if (st < ld_stall[wi]) st++;
          else begin in_valid = 1'b1; in_data = ld_data[wi]; end
        end
        if (out_valid && ri < 512) begin
          if (st > 0) begin
            chk("push_hold_data", out_data, held);
            chk("push_rd_n_high", RD_n, 1'b1);
          end
          held = out_data;
          if (st < rd_stall[ri]) st++;
          else begin
            out_ready = 1'b1;
            idx = base_i + 9'(ri);
            chk("dump_data", out_data, exp_cram[idx]);
          end
        end
        @(negedge clock);
        cyc++;
      end
    end
    if (!got_done) chk("done_timeout", 1'b0, 1'b1);
    chk("busy_held", busy_bad, 1'b0);
    chk("entries_moved", op_i ? ri : wi, n);
    @(negedge clock);
    chk("done_one_cycle", {done, busy}, 2'b00);
    if (!op_i) begin
      for (int i = 0; i < n; i++) begin
        idx = base_i + 9'(i);
        exp_cram[idx] = ld_data[i];
      end
      mism = 0;
      for (int i = 0; i < 512; i++) if (cram[i] !== exp_cram[i]) mism++;
      chk("cram_contents", mism, 0);
    end
    if (sc_i) chk("cr_reg", vce_cr, cr_i);
  endtask

  typedef struct {
    logic       op;
    logic       sc;
    logic [7:0] cr;
    logic [8:0] base;
    logic [8:0] cnt;
    logic [8:0] d0;
    logic [8:0] d1;
    int         lat;
  } vec_t;

  vec_t        tbl [6];
  logic [11:0] exp_log [5];

  initial begin
    int cyc, n, stalls;
    logic       r_op, r_sc;
    logic [8:0] r_base, r_cnt;

    tbl[0] = '{1'b0, 1'b1, 8'h02, 9'h010, 9'd0,   9'h1A5, 9'h000, 32};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 9'h1FF, 9'd1,   9'h001, 9'h1FE, 39};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 9'h020, 9'd3,   9'h000, 9'h000, 65};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 9'h010, 9'd0,   9'h000, 9'h000, 26};
    tbl[4] = '{1'b0, 1'b1, 8'hA5, 9'h000, 9'd511, 9'h155, 9'h0AA, 6675};
    tbl[5] = '{1'b1, 1'b1, 8'h3C, 9'h100, 9'd511, 9'h000, 9'h000, 6675};
    exp_log[0] = {1'b1, 3'd0, 8'h02};
    exp_log[1] = {1'b1, 3'd2, 8'h10};
    exp_log[2] = {1'b1, 3'd3, 8'h00};
    exp_log[3] = {1'b1, 3'd4, 8'hA5};
    exp_log[4] = {1'b1, 3'd5, 8'h01};

    for (int i = 0; i < 512; i++) begin
      cram[i] = 9'($urandom);
      exp_cram[i] = cram[i];
    end
    cram[9'h020] = 9'h000; cram[9'h021] = 9'h0FF; cram[9'h022] = 9'h100; cram[9'h023] = 9'h1FF;
    for (int i = 32'h20; i < 32'h24; i++) exp_cram[i] = cram[i];

    // Reset held with random inputs: bus idle, no activity.
    #1 reset_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("reset_outputs",
          {RD_n, WR_n, CS_n, busy, done, D_oe, in_ready, out_valid, A, D_out, out_data},
          {8'b11100000, 3'd0, 8'd0, 9'd0});
      start = 1'($urandom); op = 1'($urandom); set_cr = 1'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom); base = 9'($urandom);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2 reset_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_after_reset", {CS_n, RD_n, WR_n, busy, done}, 5'b11100);
    end

    // Directed command table.
    for (int t = 0; t < 6; t++) begin
      clear_stalls();
      for (int i = 0; i < 512; i++) ld_data[i] = 9'($urandom);
      ld_data[0] = tbl[t].d0;
      ld_data[1] = tbl[t].d1;
      run_cmd(tbl[t].op, tbl[t].sc, tbl[t].cr, tbl[t].base, tbl[t].cnt, tbl[t].lat);
      if (t == 0) begin
        chk("single_load_accesses", bus_log.size(), 5);
        for (int i = 0; i < 5 && i < bus_log.size(); i++) chk("single_load_bus", bus_log[i], exp_log[i]);
      end
    end

    // Wrapped load with a 5-cycle stall before the second word.
    clear_stalls();
    ld_data[0] = 9'h001; ld_data[1] = 9'h1FE; ld_stall[1] = 5;
    run_cmd(1'b0, 1'b0, 8'h00, 9'h1FF, 9'd1, ref_latency(1'b0, 2, 5));
    chk("wrap_1ff", cram[9'h1FF], 9'h001);
    chk("wrap_000", cram[9'h000], 9'h1FE);

    // Dump with 10 cycles of backpressure on the second entry.
    cram[9'h020] = 9'h000; cram[9'h021] = 9'h0FF; cram[9'h022] = 9'h100; cram[9'h023] = 9'h1FF;
    for (int i = 32'h20; i < 32'h24; i++) exp_cram[i] = cram[i];
    clear_stalls();
    rd_stall[1] = 10;
    run_cmd(1'b1, 1'b0, 8'h00, 9'h020, 9'd3, ref_latency(1'b0, 4, 10));
    chk("bp_cta_after", cta, 9'h024);

    // Reset during WR_LO phase 1 abandons the access asynchronously.
    @(negedge clock);
    in_valid = 1'b1; in_data = 9'h0AA; op = 1'b0; set_cr = 1'b1; cr_val = 8'h11;
    base = 9'h050; count = 9'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!(A == 3'd4 && !WR_n) && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    chk("reach_wr_lo", (A == 3'd4) && !WR_n, 1'b1);
    @(negedge clock);
    #1 reset_N = 1'b0;
    #1 chk("async_reset_strobes", {WR_n, CS_n, busy}, 3'b110);
    in_valid = 1'b0;
    @(negedge clock);
    #2 reset_N = 1'b1;
    clear_stalls();
    for (int i = 0; i < 3; i++) ld_data[i] = 9'($urandom);
    run_cmd(1'b0, 1'b1, 8'h22, 9'h050, 9'd2, ref_latency(1'b1, 3, 0));

    // Randomized commands against the reference CRAM and latency formula.
    for (int r = 0; r < 12; r++) begin
      clear_stalls();
      r_op   = 1'($urandom);
      r_sc   = 1'($urandom);
      r_base = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(32'h1F8, 32'h1FF)) : 9'($urandom);
      r_cnt  = 9'($urandom_range(0, 15));
      n      = int'(r_cnt) + 1;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
        ld_data[i] = 9'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          if (r_op) rd_stall[i] = $urandom_range(1, 4);
          else      ld_stall[i] = $urandom_range(1, 4);
          stalls += r_op ? rd_stall[i] : ld_stall[i];
        end
      end
      run_cmd(r_op, r_sc, 8'($urandom), r_base, r_cnt, ref_latency(r_sc, n, stalls));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
